// File: rtl/rcc_vsw_ctrl_gen.sv
// VSW backup-domain control register: NCH LSE channels with CSS,
// write-once RTC source select and a self-timed backup-domain reset.
module rcc_vsw_ctrl_gen #(
   parameter int NCH         = 1,
   parameter int SEL_W       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int BDRST_CYC   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_en_i,
   input  logic [3:0]         wr_be_i,
   input  logic [31:0]        wr_data_i,
   output logic [31:0]        rd_data_o,
   input  logic [NCH-1:0]     osc_rdy_i,
   input  logic [NCH-1:0]     css_fail_i,
   output logic [NCH-1:0]     osc_on_o,
   output logic [NCH-1:0]     osc_byp_o,
   output logic [2*NCH-1:0]   osc_drv_o,
   output logic [NCH-1:0]     css_on_o,
   output logic [NCH-1:0]     cssd_o,
   output logic               css_irq_o,
   output logic               rtc_en_o,
   output logic [SEL_W-1:0]   rtc_sel_o,
   output logic               bd_rst_o
);

   localparam int CW = (BDRST_CYC > 1) ? $clog2(BDRST_CYC) : 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [SYNC_STAGES-1:0][NCH-1:0] rdy_sq;
   logic [SYNC_STAGES-1:0][NCH-1:0] css_sq;
   logic [NCH-1:0] css_prev_q;
   logic [NCH-1:0] rdy_s, css_s, fail_evt;
   logic           any_fail;

   logic [NCH-1:0]   on_q, on_d, byp_q, byp_d;
   logic [NCH-1:0]   css_on_q, css_on_d, cssd_q, cssd_d;
   logic [2*NCH-1:0] drv_q, drv_d;
   logic [SEL_W-1:0] rtc_sel_q, rtc_sel_d;
   logic             rtc_en_q, rtc_en_d;
   logic             lock_q, lock_d;
   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic busy, start, wr_acc;
   logic unused_w;

   assign unused_w = ^{wr_data_i, wr_be_i};

   // Synchronisers are only cleared by the async reset, never by bdrst
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdy_sq     <= '0;
         css_sq     <= '0;
         css_prev_q <= '0;
      end else begin
         rdy_sq     <= {rdy_sq[SYNC_STAGES-2:0], osc_rdy_i};
         css_sq     <= {css_sq[SYNC_STAGES-2:0], css_fail_i};
         css_prev_q <= css_sq[SYNC_STAGES-1];
      end
   end

   assign rdy_s    = rdy_sq[SYNC_STAGES-1];
   assign css_s    = css_sq[SYNC_STAGES-1];
   assign fail_evt = css_s & ~css_prev_q & css_on_q;
   assign any_fail = |fail_evt;

   assign busy   = (state_q == BUSY);
   assign start  = wr_en_i && !busy && wr_be_i[3] && wr_data_i[24];
   assign wr_acc = wr_en_i && !busy && !(wr_be_i[3] && wr_data_i[24]);

   always_comb begin
      on_d      = on_q;
      byp_d     = byp_q;
      drv_d     = drv_q;
      css_on_d  = css_on_q;
      cssd_d    = cssd_q;
      rtc_sel_d = rtc_sel_q;
      rtc_en_d  = rtc_en_q;
      lock_d    = lock_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      if (start) begin
         on_d      = '0;
         byp_d     = '0;
         drv_d     = '0;
         css_on_d  = '0;
         cssd_d    = '0;
         rtc_sel_d = '0;
         rtc_en_d  = 1'b0;
         lock_d    = 1'b0;
         state_d   = BUSY;
         cnt_d     = CW'(BDRST_CYC - 1);
      end else begin
         if (busy) begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         for (int k = 0; k < NCH; k++) begin
            if (wr_acc && wr_be_i[k]) begin
               on_d[k]        = wr_data_i[8*k];
               byp_d[k]       = wr_data_i[8*k+2];
               drv_d[2*k +: 2] = wr_data_i[8*k+3 +: 2];
               if (wr_data_i[8*k+5]) css_on_d[k] = 1'b1;
            end
            if (fail_evt[k]) css_on_d[k] = 1'b0;
            cssd_d[k] = cssd_q[k] | fail_evt[k];
         end
         if (any_fail) lock_d = 1'b0;
         if (wr_acc && wr_be_i[2]) begin
            rtc_en_d = wr_data_i[23];
            if (!lock_q || any_fail) begin
               rtc_sel_d = wr_data_i[16 +: SEL_W];
               lock_d    = |wr_data_i[16 +: SEL_W];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         on_q      <= '0;
         byp_q     <= '0;
         drv_q     <= '0;
         css_on_q  <= '0;
         cssd_q    <= '0;
         rtc_sel_q <= '0;
         rtc_en_q  <= 1'b0;
         lock_q    <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
      end else begin
         on_q      <= on_d;
         byp_q     <= byp_d;
         drv_q     <= drv_d;
         css_on_q  <= css_on_d;
         cssd_q    <= cssd_d;
         rtc_sel_q <= rtc_sel_d;
         rtc_en_q  <= rtc_en_d;
         lock_q    <= lock_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k < NCH; k++) begin
         rd_data_o[8*k +: 8] = {1'b0, cssd_q[k], css_on_q[k],
                                drv_q[2*k +: 2], byp_q[k],
                                rdy_s[k], on_q[k]};
      end
      rd_data_o[16 +: SEL_W] = rtc_sel_q;
      rd_data_o[23]          = rtc_en_q;
      rd_data_o[24]          = busy;
   end

   assign osc_on_o  = on_q;
   assign osc_byp_o = byp_q;
   assign osc_drv_o = drv_q;
   assign css_on_o  = css_on_q;
   assign cssd_o    = cssd_q;
   assign css_irq_o = |cssd_q;
   assign rtc_en_o  = rtc_en_q;
   assign rtc_sel_o = rtc_sel_q;
   assign bd_rst_o  = busy;

endmodule

// File: tb/tb_rcc_vsw_ctrl_gen.sv
// Directed bench for rcc_vsw_ctrl_gen with two oscillator channels.
module tb_rcc_vsw_ctrl_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [1:0]  osc_rdy, css_fail;
   logic [1:0]  osc_on, osc_byp, css_on, cssd;
   logic [3:0]  osc_drv;
   logic        css_irq, rtc_en, bd_rst;
   logic [1:0]  rtc_sel;

   int total = 0;
   int bad   = 0;
   int hi;

   always #5 clk = ~clk;

   rcc_vsw_ctrl_gen #(
      .NCH(2), .SEL_W(2), .SYNC_STAGES(2), .BDRST_CYC(4)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_data_i(wr_data),
      .rd_data_o(rd_data),
      .osc_rdy_i(osc_rdy), .css_fail_i(css_fail),
      .osc_on_o(osc_on), .osc_byp_o(osc_byp), .osc_drv_o(osc_drv),
      .css_on_o(css_on), .cssd_o(cssd), .css_irq_o(css_irq),
      .rtc_en_o(rtc_en), .rtc_sel_o(rtc_sel), .bd_rst_o(bd_rst)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] be, input logic [31:0] d);
      wr_en = 1'b1; wr_be = be; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0; wr_data = '0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_be = '0; wr_data = '0;
      osc_rdy = '0; css_fail = '0;
      wait_n(2);
      chk("rst_rd", rd_data, 32'h0);
      chk("rst_bd", {31'd0, bd_rst}, 32'h0);
      chk("rst_on", {30'd0, osc_on}, 32'h0);
      rst = 1'b0;
      wait_n(1);

      // channel 0 configuration and ready synchroniser latency
      wr(4'b0001, 32'h1D);
      chk("cfg_on",  {30'd0, osc_on},  32'h1);
      chk("cfg_byp", {30'd0, osc_byp}, 32'h1);
      chk("cfg_drv", {28'd0, osc_drv}, 32'h3);
      chk("cfg_rd",  rd_data, 32'h1D);
      osc_rdy = 2'b01;
      wait_n(1);
      chk("rdy_1cyc", {31'd0, rd_data[1]}, 32'h0);
      wait_n(1);
      chk("rdy_2cyc", {31'd0, rd_data[1]}, 32'h1);

      // css_on is W1S; fail clears it and sets sticky cssd
      wr(4'b0001, 32'h3D);
      chk("csson_set", {30'd0, css_on}, 32'h1);
      wr(4'b0001, 32'h1D);
      chk("csson_w0", {30'd0, css_on}, 32'h1);
      css_fail = 2'b01;
      wait_n(2);
      chk("css_pre", {30'd0, css_on}, 32'h1);
      wait_n(1);
      chk("css_clr",  {30'd0, css_on}, 32'h0);
      chk("cssd_set", {30'd0, cssd}, 32'h1);
      chk("css_irq",  {31'd0, css_irq}, 32'h1);
      chk("rd_b0",    {24'd0, rd_data[7:0]}, 32'h5F);
      css_fail = 2'b00;
      wait_n(3);

      // rtc_sel write-once
      wr(4'b0100, 32'h0002_0000);
      chk("sel_2", {30'd0, rtc_sel}, 32'h2);
      wr(4'b0100, 32'h0001_0000);
      chk("sel_lock", {30'd0, rtc_sel}, 32'h2);

      // channel 1 fail ignored while its css_on is clear
      css_fail = 2'b10;
      wait_n(3);
      chk("ch1_off", {30'd0, cssd}, 32'h1);
      css_fail = 2'b00;
      wait_n(3);
      wr(4'b0010, 32'h0000_2000);
      chk("ch1_csson", {30'd0, css_on}, 32'h2);
      css_fail = 2'b10;
      wait_n(3);
      chk("ch1_cssd",  {30'd0, cssd}, 32'h3);
      chk("ch1_csson0", {30'd0, css_on}, 32'h0);
      chk("ch0_keep",  {24'd0, rd_data[7:0]}, 32'h5F);
      css_fail = 2'b00;
      wait_n(3);
      wr(4'b0100, 32'h0001_0000);
      chk("sel_unlock", {30'd0, rtc_sel}, 32'h1);

      // fail and writes in the same cycle: clear wins, sel accepted
      wr(4'b0001, 32'h3D);
      css_fail = 2'b01;
      wait_n(2);
      wr(4'b0101, 32'h0003_003D);
      chk("clr_wins", {30'd0, css_on}, 32'h0);
      chk("sel_same", {30'd0, rtc_sel}, 32'h3);
      css_fail = 2'b00;
      wr(4'b0100, 32'h0002_0000);
      chk("sel_relock", {30'd0, rtc_sel}, 32'h3);
      wait_n(2);

      // software backup-domain reset
      wr(4'b1000, 32'h0100_0000);
      chk("bd_on",   {31'd0, bd_rst}, 32'h1);
      chk("bd_rd",   rd_data, 32'h0100_0002);
      chk("bd_irq",  {31'd0, css_irq}, 32'h0);
      hi = 1;
      wr(4'b0001, 32'hFF);
      chk("bd_ign", {30'd0, osc_on}, 32'h0);
      if (bd_rst) hi++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bd_rst) hi++;
         else break;
      end
      chk("bd_len", hi, 32'd4);
      chk("bd_done", rd_data, 32'h0000_0002);

      // zero write does not lock
      wr(4'b0100, 32'h0000_0000);
      wr(4'b0100, 32'h0003_0000);
      chk("sel_z3", {30'd0, rtc_sel}, 32'h3);
      wr(4'b0100, 32'h0081_0000);
      chk("sel_z_lock", {30'd0, rtc_sel}, 32'h3);
      chk("rtc_en", {31'd0, rtc_en}, 32'h1);

      // async reset aborts the sequence
      wr(4'b1000, 32'h0100_0000);
      chk("ab_bd", {31'd0, bd_rst}, 32'h1);
      rst = 1'b1;
      #1;
      chk("ab_bd0", {31'd0, bd_rst}, 32'h0);
      chk("ab_rd",  rd_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_n(1);

      // bdrst takes priority over other lanes
      wr(4'b1001, 32'h0100_001D);
      chk("pri_on", {30'd0, osc_on}, 32'h0);
      chk("pri_bd", {31'd0, bd_rst}, 32'h1);
      for (int i = 0; i < 10; i++) begin
         if (!bd_rst) break;
         @(negedge clk);
      end
      chk("pri_end", {31'd0, bd_rst}, 32'h0);
      chk("pri_on2", {30'd0, osc_on}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rcc_vsw_ctrl_gen.md
Name: rcc_vsw_ctrl_gen

Overview:
Parametrised backup-domain (VSW) control register for the RCC. It generalises the single-LSE control register to NCH low-speed oscillator channels, each with its own clock-security (CSS) logic. Other additions are a write-once RTC source select of configurable width, a self-timed software backup-domain reset sequence, and input synchronisers. It sits between the RCC register bus decode and the backup-domain oscillator/RTC analog controls, and is clocked by the always-on VSW clock.

Parameters:
NCH, 1, number of oscillator channels (1..2); channel k occupies byte lane k.
SEL_W, 2, RTC source select width (1..4).
SYNC_STAGES, 2, flop stages on osc_rdy and css_fail inputs (>=2).
BDRST_CYC, 4, number of cycles bd_rst is asserted per software request (>=1).

Ports:
clk  in  1  VSW domain clock.
rst  in  1  asynchronous active-high reset.
wr_en  in  1  register write strobe, single cycle.
wr_be  in  4  byte-lane enables for wr_data.
wr_data  in  32  write data.
rd_data  out  32  current register image, combinational from state.
osc_rdy  in  NCH  oscillator ready, asynchronous.
css_fail  in  NCH  CSS failure detect, asynchronous.
osc_on  out  NCH  oscillator enable.
osc_byp  out  NCH  oscillator bypass.
osc_drv  out  2*NCH  drive strength, channel k at [2k+1:2k].
css_on  out  NCH  CSS enable.
cssd  out  NCH  CSS failure detected, sticky.
css_irq  out  1  OR of cssd.
rtc_en  out  1  RTC clock enable.
rtc_sel  out  SEL_W  RTC clock source select.
bd_rst  out  1  backup-domain reset pulse to downstream logic.

Behaviour:
- Asynchronous reset asserts every flop, including synchroniser stages, to 0. All outputs are 0 and rd_data is 0 during reset.
- Register map, channel k in byte k:
  - bit0 on (RW)
  - bit1 rdy (RO, synchronised osc_rdy)
  - bit2 byp (RW)
  - bits4:3 drv (RW)
  - bit5 css_on (W1S)
  - bit6 cssd (RO)
  - bit7 reserved (reads 0)
- Byte 2: bits[16+SEL_W-1:16] rtc_sel (write-once); bit23 rtc_en (RW).
- Byte 3: bit24 bdrst (write 1 starts the reset sequence; reads as busy).
- Unused and reserved bits read 0. Bytes for channels at index NCH and above are reserved.
- Write latency: a field updates on the clk edge where wr_en=1 and its lane enable is set. The new value is visible on outputs and rd_data the next cycle.
- Synchronisers:
  - osc_rdy and css_fail pass through SYNC_STAGES flops.
  - fail_evt[k] is a one-cycle pulse on the rising edge of synchronised css_fail[k], qualified by css_on[k]=1.
  - If css_on[k]=0, fail edges are ignored.
- css_on[k]:
  - Writing 1 sets it; writing 0 has no effect.
  - fail_evt[k] clears it.
  - If fail_evt[k] and a write-1 occur in the same cycle, the clear wins.
- cssd[k]:
  - Set by fail_evt[k].
  - Cleared only by rst or the bdrst sequence.
  - css_irq = |cssd.
- rtc_sel lock flag (internal):
  - Set when a write to rtc_sel is accepted with a nonzero value.
  - Cleared by rst, by the bdrst sequence, or by any fail_evt.
  - A write to rtc_sel is accepted only when the lock is clear, or when a fail_evt occurs in the same cycle. In that case the write is accepted and lock = (new value != 0).
  - Writes of 0 while unlocked are accepted and leave the lock clear.
- bdrst sequence:
  - Writing 1 to bit24 (wr_be[3]) while idle moves the FSM IDLE -> BUSY and loads a counter with BDRST_CYC-1.
  - In BUSY, bd_rst=1 and the counter decrements each cycle.
  - At count 0, the FSM returns to IDLE next cycle, so bd_rst is high for exactly BDRST_CYC cycles.
  - On entry to BUSY, all RW/W1S/RO-sticky fields and the lock flag reset to 0 in the same edge. Synchronisers are not reset.
  - All writes, including a bdrst re-request, are ignored while BUSY.
  - fail_evt during BUSY is ignored, because css_on is already 0.
- A write with bdrst=1 plus other lanes in the same cycle: bdrst takes priority and the other lanes are discarded.
- An asynchronous rst mid-sequence aborts it: the FSM goes to IDLE and bd_rst goes to 0 immediately.

Test Plan:
1. Reset, then write be=4'b0001, data=0x1D, then drive osc_rdy[0]=1 → osc_on=1, byp=1, drv=2'b11; rd_data[1] rises SYNC_STAGES cycles after osc_rdy[0]=1.
2. Set css_on[0], then write 0 to it → css_on stays 1. Pulse css_fail[0] → after SYNC_STAGES+1 cycles css_on=0, cssd=1, css_irq=1, rd_data[6]=1.
3. Write rtc_sel=2, then write rtc_sel=1 → rtc_sel stays 2. After a css fail event, write 1 → rtc_sel=1.
4. With SEL_W=2, write 0 then 3 → rtc_sel=3 (write of 0 does not lock); a subsequent write of 1 is ignored.
5. Write 0x01000000 with BDRST_CYC=4 → bd_rst high exactly 4 cycles and all fields read 0. A write of 0xFF to byte 0 during BUSY is ignored; rd_data[24]=1 while busy.
6. NCH=2: a fail on channel 1 with css_on[1]=0 → no cssd. With css_on[1]=1 → cssd[1]=1 only, channel 0 unchanged, rtc lock cleared. Assert rst mid-bdrst → bd_rst=0 at once.
